// File: rtl/student_alu_pkg.sv
// Shared types and constants for the pipelined Hack-style ALU.
// The control word mirrors the six Hack ALU control bits in their usual order.
package student_alu_pkg;

  localparam int ALU_WIDTH = 16;

  typedef struct packed {
    logic zx;
    logic nx;
    logic zy;
    logic ny;
    logic f;
    logic no;
  } alu_ctrl_t;

  localparam alu_ctrl_t ALU_ZERO      = 6'b101010;
  localparam alu_ctrl_t ALU_ONE       = 6'b111111;
  localparam alu_ctrl_t ALU_X_PLUS_Y  = 6'b000010;
  localparam alu_ctrl_t ALU_X_MINUS_Y = 6'b010011;
  localparam alu_ctrl_t ALU_X_AND_Y   = 6'b000000;

  function automatic alu_ctrl_t make_ctrl(input logic zx, input logic nx, input logic zy,
                                          input logic ny, input logic f, input logic no);
    alu_ctrl_t c;
    c.zx = zx;
    c.nx = nx;
    c.zy = zy;
    c.ny = ny;
    c.f  = f;
    c.no = no;
    return c;
  endfunction

endpackage

// File: rtl/student_not16.sv
// 16-bit bitwise inverter; the only primitive used for negation in the ALU.
module student_not16 (
  input  logic [15:0] in,
  output logic [15:0] out
);

  assign out = ~in;

endmodule

// File: rtl/student_alu_pipe.sv
// Two-stage pipelined Hack ALU: stage 1 holds preprocessed operands,
// stage 2 holds the result and its zero/negative flags.
module student_alu_pipe
  import student_alu_pkg::*;
#(
  parameter int WIDTH = ALU_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic             zx,
  input  logic             nx,
  input  logic             zy,
  input  logic             ny,
  input  logic             f,
  input  logic             no,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out,
  output logic             zr,
  output logic             ng
);

  // Inverters are 16 bits wide, so operands are padded up to whole chunks.
  localparam int NCH = (WIDTH + 15) / 16;
  localparam int PW  = NCH * 16;

  logic             s1_valid;
  logic             s2_valid;
  logic [WIDTH-1:0] x1;
  logic [WIDTH-1:0] y1;
  logic             s1_f;
  logic             s1_no;
  logic             s1_load;
  logic             s2_load;

  logic [WIDTH-1:0] xz;
  logic [WIDTH-1:0] yz;
  logic [WIDTH-1:0] x_pre;
  logic [WIDTH-1:0] y_pre;
  logic [WIDTH-1:0] t;
  logic [WIDTH-1:0] res;
  logic [PW-1:0]    xz_p;
  logic [PW-1:0]    yz_p;
  logic [PW-1:0]    t_p;
  logic [PW-1:0]    xn_p;
  logic [PW-1:0]    yn_p;
  logic [PW-1:0]    tn_p;

  // Handshake: a beat moves whenever valid and ready are both high at a rising
  // edge; ready never looks at valid, and each stage refills as soon as its
  // current beat leaves, so the pipe streams at one beat per cycle.
  assign s2_load   = !s2_valid || out_ready;
  assign s1_load   = !s1_valid || s2_load;
  assign in_ready  = s1_load;
  assign out_valid = s2_valid;

  assign xz   = zx ? '0 : x;
  assign yz   = zy ? '0 : y;
  assign xz_p = PW'(xz);
  assign yz_p = PW'(yz);
  assign t    = s1_f ? (x1 + y1) : (x1 & y1);
  assign t_p  = PW'(t);

  for (genvar i = 0; i < NCH; i++) begin : g_not
    student_not16 u_not_x (.in(xz_p[i*16 +: 16]), .out(xn_p[i*16 +: 16]));
    student_not16 u_not_y (.in(yz_p[i*16 +: 16]), .out(yn_p[i*16 +: 16]));
    student_not16 u_not_t (.in(t_p[i*16 +: 16]),  .out(tn_p[i*16 +: 16]));
  end

  assign x_pre = nx ? xn_p[WIDTH-1:0] : xz;
  assign y_pre = ny ? yn_p[WIDTH-1:0] : yz;
  assign res   = s1_no ? tn_p[WIDTH-1:0] : t;

  // Data registers only load alongside a valid beat, so bubbles leave them untouched.
  always_ff @(posedge clk) begin
    if (reset) begin
      s1_valid <= 1'b0;
      s2_valid <= 1'b0;
      out      <= '0;
      zr       <= 1'b0;
      ng       <= 1'b0;
    end else begin
      if (s1_load) begin
        s1_valid <= in_valid;
        if (in_valid) begin
          x1    <= x_pre;
          y1    <= y_pre;
          s1_f  <= f;
          s1_no <= no;
        end
      end
      if (s2_load) begin
        s2_valid <= s1_valid;
        if (s1_valid) begin
          out <= res;
          zr  <= (res == '0);
          ng  <= res[WIDTH-1];
        end
      end
    end
  end

endmodule
